// File: rtl/axi_lite_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// axi_lite_arbiter_2to1
//
// Shares one downstream AXI4-lite slave port between two upstream AXI4-lite
// requesters (p0, p1). One transaction (a single read or a single write) is in
// flight at a time. The grant is taken in the IDLE cycle and held from the
// address phase until the response handshake.
//
// Arbitration on a tie is round-robin by default. Defining the macro
// AXI_ARB_FIXED_PRIO_EN makes p0 win every tie instead.
//
// Parameters:
//   ADDR_W  address width of all ports
//   DATA_W  data width; strobe width is DATA_W/8
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   pN_aw* / pN_w* / pN_b*       write channels of requester N (N = 0, 1)
//   pN_ar* / pN_r*               read channels of requester N
//   m_aw* / m_w* / m_b*          write channels towards the slave
//   m_ar* / m_r*                 read channels towards the slave
//   grant                        one-hot owner, 0 while idle
// -----------------------------------------------------------------------------
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                p0_awvalid,
    input  logic [ADDR_W-1:0]   p0_awaddr,
    input  logic [2:0]          p0_awprot,
    output logic                p0_awready,
    input  logic                p0_wvalid,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wstrb,
    output logic                p0_wready,
    output logic                p0_bvalid,
    input  logic                p0_bready,
    input  logic                p0_arvalid,
    input  logic [ADDR_W-1:0]   p0_araddr,
    input  logic [2:0]          p0_arprot,
    output logic                p0_arready,
    output logic                p0_rvalid,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p0_rready,

    input  logic                p1_awvalid,
    input  logic [ADDR_W-1:0]   p1_awaddr,
    input  logic [2:0]          p1_awprot,
    output logic                p1_awready,
    input  logic                p1_wvalid,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wstrb,
    output logic                p1_wready,
    output logic                p1_bvalid,
    input  logic                p1_bready,
    input  logic                p1_arvalid,
    input  logic [ADDR_W-1:0]   p1_araddr,
    input  logic [2:0]          p1_arprot,
    output logic                p1_arready,
    output logic                p1_rvalid,
    output logic [DATA_W-1:0]   p1_rdata,
    input  logic                p1_rready,

    output logic                m_awvalid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    input  logic                m_awready,
    output logic                m_wvalid,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wready,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic                m_arvalid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                m_rready,

    output logic [1:0]          grant
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_RESP,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner;
    logic   last;
    logic   aw_done;
    logic   w_done;

    // A request is an address on either channel; wvalid alone does not count.
    logic req0;
    logic req1;
    assign req0 = p0_arvalid | p0_awvalid;
    assign req1 = p1_arvalid | p1_awvalid;

    // Winner of the arbitration performed in IDLE.
    logic pick;
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        pick = 1'b0;
        if (req0 && req1) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
            pick = 1'b0;
`else
            pick = ~last;
`endif
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    logic pick_arvalid;
    assign pick_arvalid = pick ? p1_arvalid : p0_arvalid;

    // Owner-side view of the upstream inputs.
    logic                own_arvalid;
    logic [ADDR_W-1:0]   own_araddr;
    logic [2:0]          own_arprot;
    logic                own_awvalid;
    logic [ADDR_W-1:0]   own_awaddr;
    logic [2:0]          own_awprot;
    logic                own_wvalid;
    logic [DATA_W-1:0]   own_wdata;
    logic [DATA_W/8-1:0] own_wstrb;
    logic                own_rready;
    logic                own_bready;

    assign own_arvalid = owner ? p1_arvalid : p0_arvalid;
    assign own_araddr  = owner ? p1_araddr  : p0_araddr;
    assign own_arprot  = owner ? p1_arprot  : p0_arprot;
    assign own_awvalid = owner ? p1_awvalid : p0_awvalid;
    assign own_awaddr  = owner ? p1_awaddr  : p0_awaddr;
    assign own_awprot  = owner ? p1_awprot  : p0_awprot;
    assign own_wvalid  = owner ? p1_wvalid  : p0_wvalid;
    assign own_wdata   = owner ? p1_wdata   : p0_wdata;
    assign own_wstrb   = owner ? p1_wstrb   : p0_wstrb;
    assign own_rready  = owner ? p1_rready  : p0_rready;
    assign own_bready  = owner ? p1_bready  : p0_bready;

    // Downstream handshakes; the forwarded valids are already 0 outside the
    // state that owns each channel.
    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid  & m_rready;
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid  & m_wready;
    assign b_hs  = m_bvalid  & m_bready;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples values from before the edge.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = pick_arvalid ? RD_ADDR : WR_REQ;
            RD_ADDR: if (ar_hs)              state_nxt = RD_RESP;
            RD_RESP: if (r_hs)               state_nxt = IDLE;
            WR_REQ:  if (aw_done && w_done)  state_nxt = WR_RESP;
            WR_RESP: if (b_hs)               state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Owner, round-robin history and write-phase completion flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner   <= 1'b0;
            last    <= 1'b1;   // p0 wins the first tie
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (state == IDLE && (req0 || req1)) owner <= pick;
            if (r_hs || b_hs)                    last  <= owner;
            if (aw_hs)                           aw_done <= 1'b1;
            if (w_hs)                            w_done  <= 1'b1;
            if (b_hs) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    // Output logic: purely combinational from state/owner/flags, so reset
    // forces every valid, ready and grant to 0 immediately.
    always_comb begin
        m_awvalid  = 1'b0;
        m_awaddr   = '0;
        m_awprot   = '0;
        m_wvalid   = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_bready   = 1'b0;
        m_arvalid  = 1'b0;
        m_araddr   = '0;
        m_arprot   = '0;
        m_rready   = 1'b0;
        p0_awready = 1'b0;
        p0_wready  = 1'b0;
        p0_bvalid  = 1'b0;
        p0_arready = 1'b0;
        p0_rvalid  = 1'b0;
        p0_rdata   = '0;
        p1_awready = 1'b0;
        p1_wready  = 1'b0;
        p1_bvalid  = 1'b0;
        p1_arready = 1'b0;
        p1_rvalid  = 1'b0;
        p1_rdata   = '0;
        grant      = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

        case (state)
            RD_ADDR: begin
                m_arvalid = own_arvalid;
                m_araddr  = own_araddr;
                m_arprot  = own_arprot;
                if (owner) p1_arready = m_arready;
                else       p0_arready = m_arready;
            end
            RD_RESP: begin
                m_rready = own_rready;
                if (owner) begin
                    p1_rvalid = m_rvalid;
                    p1_rdata  = m_rdata;
                end else begin
                    p0_rvalid = m_rvalid;
                    p0_rdata  = m_rdata;
                end
            end
            WR_REQ: begin
                // aw and w complete independently; a finished channel stays
                // quiet so the slave never sees it twice.
                if (!aw_done) begin
                    m_awvalid = own_awvalid;
                    m_awaddr  = own_awaddr;
                    m_awprot  = own_awprot;
                    if (owner) p1_awready = m_awready;
                    else       p0_awready = m_awready;
                end
                if (!w_done) begin
                    m_wvalid = own_wvalid;
                    m_wdata  = own_wdata;
                    m_wstrb  = own_wstrb;
                    if (owner) p1_wready = m_wready;
                    else       p0_wready = m_wready;
                end
            end
            WR_RESP: begin
                m_bready = own_bready;
                if (owner) p1_bvalid = m_bvalid;
                else       p0_bvalid = m_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_arbiter_2to1
//
// Directed bench for axi_lite_arbiter_2to1. The bench plays both requesters
// and the slave; expected grants, read data and write payloads are queued
// when stimulus is set up and popped when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_axi_lite_arbiter_2to1;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic clk;
    logic resetn;

    logic        p0_awvalid, p0_awready, p0_wvalid, p0_wready, p0_bvalid, p0_bready;
    logic        p0_arvalid, p0_arready, p0_rvalid, p0_rready;
    logic [31:0] p0_awaddr, p0_araddr, p0_wdata, p0_rdata;
    logic [2:0]  p0_awprot, p0_arprot;
    logic [3:0]  p0_wstrb;

    logic        p1_awvalid, p1_awready, p1_wvalid, p1_wready, p1_bvalid, p1_bready;
    logic        p1_arvalid, p1_arready, p1_rvalid, p1_rready;
    logic [31:0] p1_awaddr, p1_araddr, p1_wdata, p1_rdata;
    logic [2:0]  p1_awprot, p1_arprot;
    logic [3:0]  p1_wstrb;

    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;

    logic [1:0]  gnt_q[$];
    logic [31:0] rd_q[$];
    wr_t         wr_q[$];

    axi_lite_arbiter_2to1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .p0_awvalid (p0_awvalid), .p0_awaddr (p0_awaddr), .p0_awprot (p0_awprot),
        .p0_awready (p0_awready),
        .p0_wvalid  (p0_wvalid),  .p0_wdata  (p0_wdata),  .p0_wstrb  (p0_wstrb),
        .p0_wready  (p0_wready),
        .p0_bvalid  (p0_bvalid),  .p0_bready (p0_bready),
        .p0_arvalid (p0_arvalid), .p0_araddr (p0_araddr), .p0_arprot (p0_arprot),
        .p0_arready (p0_arready),
        .p0_rvalid  (p0_rvalid),  .p0_rdata  (p0_rdata),  .p0_rready (p0_rready),
        .p1_awvalid (p1_awvalid), .p1_awaddr (p1_awaddr), .p1_awprot (p1_awprot),
        .p1_awready (p1_awready),
        .p1_wvalid  (p1_wvalid),  .p1_wdata  (p1_wdata),  .p1_wstrb  (p1_wstrb),
        .p1_wready  (p1_wready),
        .p1_bvalid  (p1_bvalid),  .p1_bready (p1_bready),
        .p1_arvalid (p1_arvalid), .p1_araddr (p1_araddr), .p1_arprot (p1_arprot),
        .p1_arready (p1_arready),
        .p1_rvalid  (p1_rvalid),  .p1_rdata  (p1_rdata),  .p1_rready (p1_rready),
        .m_awvalid  (m_awvalid),  .m_awaddr  (m_awaddr),  .m_awprot  (m_awprot),
        .m_awready  (m_awready),
        .m_wvalid   (m_wvalid),   .m_wdata   (m_wdata),   .m_wstrb   (m_wstrb),
        .m_wready   (m_wready),
        .m_bvalid   (m_bvalid),   .m_bready  (m_bready),
        .m_arvalid  (m_arvalid),  .m_araddr  (m_araddr),  .m_arprot  (m_arprot),
        .m_arready  (m_arready),
        .m_rvalid   (m_rvalid),   .m_rdata   (m_rdata),   .m_rready  (m_rready),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Slave side of one read; the owner is taken from the grant queue.
    task automatic serve_read(input bit keep);
        logic [1:0]  g;
        logic [31:0] a;
        logic [31:0] d;
        bit          n;
        int          k;
        g = gnt_q.pop_front();
        n = (g == 2'b10);
        a = n ? p1_araddr : p0_araddr;
        d = 32'hA500_0000 | 32'(rd_cnt);
        rd_cnt++;
        k = 0;
        while (m_arvalid !== 1'b1 && k < 20) begin
            next_cycle();
            k++;
        end
        check("ar_forwarded", m_arvalid, 1);
        check("rd_grant", grant, g);
        check("m_araddr", m_araddr, a);
        m_arready = 1'b1;
        #1;
        check("arready_owner", n ? p1_arready : p0_arready, 1);
        check("arready_other", n ? p0_arready : p1_arready, 0);
        next_cycle();
        m_arready = 1'b0;
        if (!keep) begin
            if (n) p1_arvalid = 1'b0;
            else   p0_arvalid = 1'b0;
        end
        rd_q.push_back(d);
        m_rvalid  = 1'b1;
        m_rdata   = d;
        p0_rready = !n;
        p1_rready = n;
        #1;
        check("rvalid_owner", n ? p1_rvalid : p0_rvalid, 1);
        check("rvalid_other", n ? p0_rvalid : p1_rvalid, 0);
        check("rdata_owner", n ? p1_rdata : p0_rdata, rd_q.pop_front());
        check("rdata_other", n ? p0_rdata : p1_rdata, 0);
        check("m_rready", m_rready, 1);
        next_cycle();
        m_rvalid = 1'b0;
        m_rdata  = '0;
        #1;
        check("rd_back_idle", grant, 0);
    endtask

    // Slave side of one write with aw/w accepted together and bvalid delayed.
    task automatic serve_write(input bit n, input int b_delay, input bit raise_ar);
        wr_t e;
        int  k;
        e = wr_q.pop_front();
        k = 0;
        while (m_awvalid !== 1'b1 && m_wvalid !== 1'b1 && k < 20) begin
            next_cycle();
            k++;
        end
        check("wr_grant", grant, n ? 2'b10 : 2'b01);
        m_awready = 1'b1;
        m_wready  = 1'b1;
        #1;
        check("m_awaddr", m_awaddr, e.addr);
        check("m_wdata", m_wdata, e.data);
        check("m_wstrb", m_wstrb, e.strb);
        check("awready_owner", n ? p1_awready : p0_awready, 1);
        check("wready_owner", n ? p1_wready : p0_wready, 1);
        check("awready_other", n ? p0_awready : p1_awready, 0);
        next_cycle();
        m_awready = 1'b0;
        m_wready  = 1'b0;
        if (n) begin p1_awvalid = 1'b0; p1_wvalid = 1'b0; end
        else   begin p0_awvalid = 1'b0; p0_wvalid = 1'b0; end
        #1;
        check("aw_quiet_after_done", m_awvalid, 0);
        check("w_quiet_after_done", m_wvalid, 0);
        next_cycle();
        if (raise_ar) p0_arvalid = 1'b1;
        p0_bready = !n;
        p1_bready = n;
        for (int i = 0; i < b_delay; i++) begin
            m_arready = 1'b1;
            #1;
            check("b_wait_grant", grant, n ? 2'b10 : 2'b01);
            check("b_wait_bvalid", n ? p1_bvalid : p0_bvalid, 0);
            check("b_wait_arready", p0_arready, 0);
            check("b_wait_m_arvalid", m_arvalid, 0);
            next_cycle();
        end
        m_arready = 1'b0;
        m_bvalid  = 1'b1;
        #1;
        check("bvalid_owner", n ? p1_bvalid : p0_bvalid, 1);
        check("bvalid_other", n ? p0_bvalid : p1_bvalid, 0);
        check("m_bready", m_bready, 1);
        next_cycle();
        m_bvalid = 1'b0;
        #1;
        check("wr_back_idle", grant, 0);
    endtask

    initial begin
        resetn = 1'b0;
        {p0_awvalid, p0_wvalid, p0_arvalid, p0_bready, p0_rready} = '0;
        {p1_awvalid, p1_wvalid, p1_arvalid, p1_bready, p1_rready} = '0;
        p0_awaddr = '0; p0_araddr = '0; p0_wdata = '0; p0_wstrb = '0;
        p1_awaddr = '0; p1_araddr = '0; p1_wdata = '0; p1_wstrb = '0;
        p0_awprot = '0; p0_arprot = '0; p1_awprot = '0; p1_arprot = '0;
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        m_rdata = '0;

        // Reset state
        next_cycle();
        next_cycle();
        check("reset_grant", grant, 0);
        check("reset_m_arvalid", m_arvalid, 0);
        check("reset_m_awvalid", m_awvalid, 0);
        resetn = 1'b1;
        next_cycle();

        // p0 single read: one IDLE cycle of latency, then grant 01
        p0_arvalid = 1'b1;
        p0_araddr  = 32'h100;
        #1;
        check("idle_latency_grant", grant, 0);
        check("idle_latency_arvalid", m_arvalid, 0);
        gnt_q.push_back(2'b01);
        serve_read(1'b0);

        // p1 write with wvalid two cycles ahead of awvalid; slave takes w first
        p1_wvalid = 1'b1;
        p1_wdata  = 32'h1234_5678;
        p1_wstrb  = 4'hF;
        #1;
        check("wvalid_alone_no_grant", grant, 0);
        next_cycle();
        check("wvalid_alone_no_grant2", grant, 0);
        next_cycle();
        p1_awvalid = 1'b1;
        p1_awaddr  = 32'h20;
        wr_q.push_back('{addr: 32'h20, data: 32'h1234_5678, strb: 4'hF});
        next_cycle();
        m_wready  = 1'b1;
        m_awready = 1'b0;
        #1;
        check("p1wr_grant", grant, 2'b10);
        check("p1wr_m_wvalid", m_wvalid, 1);
        check("p1wr_wready", p1_wready, 1);
        check("p1wr_awready_held", p1_awready, 0);
        begin
            wr_t e;
            e = wr_q.pop_front();
            check("p1wr_wdata", m_wdata, e.data);
            check("p1wr_wstrb", m_wstrb, e.strb);
            next_cycle();
            p1_wvalid = 1'b0;
            m_wready  = 1'b0;
            m_awready = 1'b1;
            #1;
            check("p1wr_w_done", m_wvalid, 0);
            check("p1wr_m_awvalid", m_awvalid, 1);
            check("p1wr_awaddr", m_awaddr, e.addr);
            check("p1wr_awready", p1_awready, 1);
        end
        next_cycle();
        p1_awvalid = 1'b0;
        m_awready  = 1'b0;
        #1;
        check("p1wr_aw_not_again", m_awvalid, 0);
        check("p1wr_hold_grant", grant, 2'b10);
        next_cycle();
        p1_bready = 1'b1;
        m_bvalid  = 1'b1;
        #1;
        check("p1wr_aw_not_again2", m_awvalid, 0);
        check("p1wr_bvalid", p1_bvalid, 1);
        check("p1wr_p0_bvalid", p0_bvalid, 0);
        next_cycle();
        m_bvalid = 1'b0;
        #1;
        check("p1wr_idle", grant, 0);
        check("p1wr_single_b", p1_bvalid, 0);

        // Both requesters reading continuously
        p0_arvalid = 1'b1; p0_araddr = 32'h100;
        p1_arvalid = 1'b1; p1_araddr = 32'h200;
`ifdef AXI_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) gnt_q.push_back(2'b01);
`else
        for (int i = 0; i < 4; i++) gnt_q.push_back(i[0] ? 2'b10 : 2'b01);
`endif
        for (int i = 0; i < 4; i++) serve_read(1'b1);
        p0_arvalid = 1'b0;
        p1_arvalid = 1'b0;
        next_cycle();

        // p0 arvalid + awvalid together: read first, then the write
        p0_arvalid = 1'b1; p0_araddr = 32'h300;
        p0_awvalid = 1'b1; p0_awaddr = 32'h30;
        p0_wvalid  = 1'b1; p0_wdata  = 32'h0BAD_F00D; p0_wstrb = 4'hC;
        wr_q.push_back('{addr: 32'h30, data: 32'h0BAD_F00D, strb: 4'hC});
        gnt_q.push_back(2'b01);
        serve_read(1'b0);
        serve_write(1'b0, 1, 1'b0);
        next_cycle();

        // p0 write with bvalid 5 cycles late; its read waits for the grant
        p0_awvalid = 1'b1; p0_awaddr = 32'h40;
        p0_wvalid  = 1'b1; p0_wdata  = 32'hCAFE_F00D; p0_wstrb = 4'h3;
        p0_araddr  = 32'h400;
        wr_q.push_back('{addr: 32'h40, data: 32'hCAFE_F00D, strb: 4'h3});
        serve_write(1'b0, 5, 1'b1);
        gnt_q.push_back(2'b01);
        serve_read(1'b0);
        next_cycle();

        // Reset while in RD_RESP
        p0_arvalid = 1'b1; p0_araddr = 32'h500;
        next_cycle();
        m_arready = 1'b1;
        next_cycle();
        p0_arvalid = 1'b0;
        m_arready  = 1'b0;
        m_rvalid   = 1'b1;
        m_rdata    = 32'h5555_AAAA;
        p0_rready  = 1'b1;
        #1;
        check("pre_reset_rvalid", p0_rvalid, 1);
        resetn = 1'b0;
        #1;
        check("mid_reset_grant", grant, 0);
        check("mid_reset_rvalid", p0_rvalid, 0);
        check("mid_reset_rdata", p0_rdata, 0);
        check("mid_reset_m_rready", m_rready, 0);
        m_rvalid = 1'b0;
        m_rdata  = '0;
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        // First tie after reset goes to p0, then p1 is served
        p0_arvalid = 1'b1; p0_araddr = 32'h600;
        p1_arvalid = 1'b1; p1_araddr = 32'h700;
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        serve_read(1'b0);
        serve_read(1'b0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
Name: axi_lite_arbiter_2to1

Overview:
- Shares one downstream AXI4-lite slave port between two upstream AXI4-lite requesters, e.g. the NoRISC instruction-fetch port (p0) and data port (p1).
- Exactly one transaction (one read or one write) is in flight at a time.
- The grant is held from the address phase until the response handshake.
- Arbitration is round-robin by default; fixed priority is a compile-time option.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  input  1  single clock, all logic on posedge.
- resetn  input  1  asynchronous active-low reset.
- pN_awvalid/pN_awaddr/pN_awprot  input  1/ADDR_W/3  write address from requester N (N=0,1).
- pN_awready  output  1  write address accept to requester N.
- pN_wvalid/pN_wdata/pN_wstrb  input  1/DATA_W/DATA_W/8  write data from requester N.
- pN_wready  output  1  write data accept.
- pN_bvalid  output  1  write response valid; pN_bready  input  1.
- pN_arvalid/pN_araddr/pN_arprot  input  1/ADDR_W/3  read address; pN_arready  output  1.
- pN_rvalid/pN_rdata  output  1/DATA_W  read response; pN_rready  input  1.
- m_awvalid/m_awaddr/m_awprot  output  1/ADDR_W/3  to slave; m_awready  input  1.
- m_wvalid/m_wdata/m_wstrb  output  1/DATA_W/DATA_W/8; m_wready  input  1.
- m_bvalid  input  1; m_bready  output  1.
- m_arvalid/m_araddr/m_arprot  output  1/ADDR_W/3; m_arready  input  1.
- m_rvalid/m_rdata  input  1/DATA_W; m_rready  output  1.
- grant  output  2  one-hot owner (bit N = requester N), 0 when idle.

Behaviour:
- States: IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP. Registers: state, owner (1b), last (1b), aw_done, w_done.
- Reset (async, resetn=0): state=IDLE, last=1 (p0 wins first tie), aw_done=w_done=0. All outputs are combinational from state, so every valid/ready output and grant is 0 during and after reset.
- Request from requester N: reqN = pN_arvalid | pN_awvalid. wvalid alone is not a request.
- IDLE:
  - If any reqN=1, pick the owner: both requesting -> owner = ~last; otherwise the sole requester.
  - Next state is RD_ADDR if the owner's arvalid=1 (reads win over writes within one requester), else WR_REQ.
  - This gives one cycle of grant latency: no channel is forwarded in the IDLE cycle.
- RD_ADDR:
  - Owner's ar channel is forwarded to m_ar*; pOwner_arready = m_arready.
  - On m_ar handshake -> RD_RESP.
- RD_RESP:
  - m_rvalid/m_rdata forwarded to the owner; m_rready = pOwner_rready.
  - On r handshake -> IDLE, last <= owner.
- WR_REQ:
  - aw and w are forwarded independently: m_awvalid = pOwner_awvalid & ~aw_done, m_wvalid = pOwner_wvalid & ~w_done.
  - Readys to the owner are masked by the same done flags.
  - An aw handshake sets aw_done; a w handshake sets w_done. Both may occur in the same cycle, in either order.
  - When both flags are set (registered) -> WR_RESP.
- WR_RESP:
  - m_bvalid forwarded to the owner; m_bready = pOwner_bready.
  - On b handshake -> IDLE, clear both flags, last <= owner.
- Non-owner requester: all its readys, bvalid and rvalid are 0. Its rdata is 0.
- m_* payload outputs are 0 when no channel is forwarded.
- grant[owner]=1 in every non-IDLE state.
- Back-to-back: minimum read is 3 cycles (IDLE, RD_ADDR, RD_RESP) with a zero-wait slave. A requester that is still requesting after completion re-enters arbitration in the next IDLE cycle.
- Reset mid-transaction: return immediately to IDLE and drop all valids. The in-flight slave transaction is abandoned; the slave is reset by the same resetn.
- A requester withdrawing valid before its handshake is illegal AXI. The arbiter keeps the grant and waits.

Optional Feature:
- Macro AXI_ARB_FIXED_PRIO_EN.
- Defined: on a tie in IDLE, p0 always wins; last is ignored.
- Undefined: round-robin via last as described above.
- All other behaviour is identical in both cases.

Test Plan:
- p0 read, araddr=0x100, slave returns 0xDEADBEEF one cycle after the ar handshake -> grant=01 from cycle 1; p0_rdata=0xDEADBEEF with p0_rvalid=1; p1 sees no valids; back to IDLE after rready.
- p0 and p1 both assert arvalid continuously for 4 transactions -> grant sequence 01,10,01,10. With AXI_ARB_FIXED_PRIO_EN: 01,01,01,01 while p0 keeps requesting.
- p1 write, awaddr=0x20, wdata=0x12345678, wstrb=0xF, with wvalid 2 cycles before awvalid -> m_wvalid asserted first with w_done set; m_aw forwarded later; one bvalid to p1; m_awvalid never re-asserted after aw_done.
- p0 asserts arvalid and awvalid in the same cycle -> read served first, then the write on a later grant (p1 idle).
- resetn dropped while in RD_RESP -> all outputs 0 the same cycle; after release, a new p1 read is granted normally with last=1 tie behaviour.
- Slave with m_bvalid delayed 5 cycles -> grant held through WR_RESP; p0 arvalid raised meanwhile gets arready=0 until the write completes.
